// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter sharing one ALU controller.
// One operation at a time: IDLE -> START (strobe) -> WAIT (finish or timeout) -> DONE (ack).
module alu_arbiter #(
  parameter int TMO_CYCLES = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic [3:0] opCode0,
  input  logic       req1,
  input  logic [3:0] opCode1,
  input  logic       IF,
  output logic       ALUstr,
  output logic [3:0] opCode,
  output logic       gnt0,
  output logic       gnt1,
  output logic       ack0,
  output logic       ack1,
  output logic       err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  localparam logic [4:0] TMO_LAST = 5'(TMO_CYCLES - 1);

  state_t     state, state_n;
  logic       owner;
  logic       ptr;
  logic       err_q;
  logic [4:0] cnt;
  logic       any_req;
  logic       sel;
  logic       timeout;

  assign any_req = req0 | req1;
  // Lone requester wins outright; under contention the pointer decides.
  assign sel     = req1 & (~req0 | ptr);
  assign timeout = (cnt == TMO_LAST);

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = START;
      START:   state_n = WAIT;
      WAIT:    if (IF || timeout) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      ptr    <= 1'b0;
      err_q  <= 1'b0;
      cnt    <= 5'd0;
      opCode <= 4'b0000;
    end else begin
      state <= state_n;
      case (state)
        IDLE: begin
          if (any_req) begin
            owner  <= sel;
            opCode <= sel ? opCode1 : opCode0;
          end
        end
        START: cnt <= 5'd0;
        WAIT: begin
          cnt   <= cnt + 5'd1;
          // A finish in the timeout cycle still counts as success.
          err_q <= ~IF & timeout;
        end
        DONE:    ptr <= ~owner;
        default: ;
      endcase
    end
  end

  assign busy   = (state != IDLE);
  assign ALUstr = (state == START);
  assign gnt0   = busy & ~owner;
  assign gnt1   = busy & owner;
  assign ack0   = (state == DONE) & ~owner;
  assign ack1   = (state == DONE) & owner;
  assign err    = (state == DONE) & err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: latency, round-robin, timeout, async reset, spurious IF.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1, IF;
  logic [3:0] opCode0, opCode1;
  logic       ALUstr, gnt0, gnt1, ack0, ack1, err, busy;
  logic [3:0] opCode;

  int passed = 0;
  int total  = 0;

  alu_arbiter #(.TMO_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .opCode0(opCode0),
    .req1(req1), .opCode1(opCode1),
    .IF(IF),
    .ALUstr(ALUstr), .opCode(opCode),
    .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
    .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one cycle; sample and drive 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; req0 = 1'b0; req1 = 1'b0; IF = 1'b0;
    opCode0 = 4'h0; opCode1 = 4'h0;
    #2;
    total++;
    if ({ALUstr, gnt0, gnt1, ack0, ack1, err, busy, opCode} !== 11'd0)
      $display("FAIL reset_outputs got=%b exp=0", {ALUstr, gnt0, gnt1, ack0, ack1, err, busy, opCode});
    else passed++;
    tick(); tick();
    reset = 1'b1;
    tick();
    total++;
    if ({busy, ALUstr} !== 2'b00) $display("FAIL reset_idle got=%b exp=00", {busy, ALUstr}); else passed++;
  endtask

  task automatic test_single();
    req0 = 1'b1; opCode0 = 4'b0010;
    tick();  // T+1
    total++;
    if ({ALUstr, gnt0, gnt1, busy, opCode} !== 8'b1101_0010)
      $display("FAIL single_start got=%b exp=11010010", {ALUstr, gnt0, gnt1, busy, opCode});
    else passed++;
    tick();  // T+2
    IF = 1'b1;
    total++;
    if ({ALUstr, gnt0, ack0} !== 3'b010) $display("FAIL single_wait got=%b exp=010", {ALUstr, gnt0, ack0}); else passed++;
    tick();  // T+3
    total++;
    if ({ack0, ack1, err, gnt0} !== 4'b1001) $display("FAIL single_ack got=%b exp=1001", {ack0, ack1, err, gnt0}); else passed++;
    IF = 1'b0; req0 = 1'b0;
    tick();  // T+4
    total++;
    if ({busy, gnt0, ack0, opCode} !== 7'b000_0010)
      $display("FAIL single_idle got=%b exp=0000010", {busy, gnt0, ack0, opCode});
    else passed++;
  endtask

  task automatic test_round_robin();
    logic [1:0] eg;
    logic [3:0] eop;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    req0 = 1'b1; req1 = 1'b1; opCode0 = 4'h3; opCode1 = 4'h5;
    for (int i = 0; i < 4; i++) begin
      eg  = (i % 2 == 1) ? 2'b10 : 2'b01;
      eop = (i % 2 == 1) ? 4'h5 : 4'h3;
      tick();  // START
      total++;
      if ({gnt1, gnt0, opCode} !== {eg, eop})
        $display("FAIL rr_grant op=%0d got=%b exp=%b", i, {gnt1, gnt0, opCode}, {eg, eop});
      else passed++;
      tick();  // WAIT
      IF = 1'b1;
      total++;
      if ({gnt1, gnt0} !== eg) $display("FAIL rr_wait_gnt op=%0d got=%b exp=%b", i, {gnt1, gnt0}, eg); else passed++;
      tick();  // DONE
      total++;
      if ({ack1, ack0, err} !== {eg, 1'b0})
        $display("FAIL rr_ack op=%0d got=%b exp=%b", i, {ack1, ack0, err}, {eg, 1'b0});
      else passed++;
      IF = 1'b0;
      if (eg[1]) req1 = 1'b0; else req0 = 1'b0;
      tick();  // IDLE
      total++;
      if ({busy, gnt1, gnt0} !== 3'b000) $display("FAIL rr_idle op=%0d got=%b exp=000", i, {busy, gnt1, gnt0}); else passed++;
      req0 = 1'b1; req1 = 1'b1;
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    logic early;
    early = 1'b0;
    req1 = 1'b1; opCode1 = 4'h9;
    tick();  // START
    total++;
    if ({ALUstr, gnt1, opCode} !== 6'b11_1001) $display("FAIL tmo_start got=%b exp=111001", {ALUstr, gnt1, opCode}); else passed++;
    tick();  // WAIT cycle 1
    for (int k = 1; k < 16; k++) begin
      if (ack0 | ack1 | ~busy | ALUstr) early = 1'b1;
      tick();
    end
    if (ack0 | ack1 | ~busy | ALUstr) early = 1'b1;  // WAIT cycle 16
    total++;
    if (early !== 1'b0) $display("FAIL tmo_early_done got=%b exp=0", early); else passed++;
    tick();  // DONE
    total++;
    if ({ack1, ack0, err} !== 3'b101) $display("FAIL tmo_ack got=%b exp=101", {ack1, ack0, err}); else passed++;
    req1 = 1'b0;
    tick();
    total++;
    if ({busy, err, opCode} !== 6'b00_1001) $display("FAIL tmo_idle got=%b exp=001001", {busy, err, opCode}); else passed++;
  endtask

  task automatic test_if_at_limit();
    req0 = 1'b1; opCode0 = 4'hC;
    tick();  // START
    tick();  // WAIT cycle 1
    for (int k = 1; k < 16; k++) tick();
    IF = 1'b1;  // WAIT cycle 16
    total++;
    if ({busy, ack0} !== 2'b10) $display("FAIL limit_wait16 got=%b exp=10", {busy, ack0}); else passed++;
    tick();  // DONE
    total++;
    if ({ack0, ack1, err} !== 3'b100) $display("FAIL limit_ack got=%b exp=100", {ack0, ack1, err}); else passed++;
    IF = 1'b0; req0 = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    req0 = 1'b1; req1 = 1'b0; opCode0 = 4'h7;
    tick(); tick(); tick();  // START, WAIT1, WAIT2
    total++;
    if ({busy, gnt0} !== 2'b11) $display("FAIL rstmid_pre got=%b exp=11", {busy, gnt0}); else passed++;
    #3;
    reset = 1'b0;
    #1;
    total++;
    if ({ALUstr, gnt0, gnt1, ack0, ack1, err, busy, opCode} !== 11'd0)
      $display("FAIL rstmid_async got=%b exp=0", {ALUstr, gnt0, gnt1, ack0, ack1, err, busy, opCode});
    else passed++;
    req1 = 1'b1; opCode1 = 4'hA;
    tick();
    total++;
    if ({ack0, ack1, busy} !== 3'b000) $display("FAIL rstmid_held got=%b exp=000", {ack0, ack1, busy}); else passed++;
    reset = 1'b1;
    tick();  // START after release
    total++;
    if ({gnt1, gnt0, opCode} !== 6'b01_0111) $display("FAIL rstmid_ptr got=%b exp=010111", {gnt1, gnt0, opCode}); else passed++;
    tick();  // WAIT
    IF = 1'b1;
    tick();  // DONE
    total++;
    if ({ack0, ack1, err} !== 3'b100) $display("FAIL rstmid_ack got=%b exp=100", {ack0, ack1, err}); else passed++;
    IF = 1'b0; req0 = 1'b0; req1 = 1'b0;
    tick();
  endtask

  task automatic test_spurious();
    req0 = 1'b1; opCode0 = 4'h6; IF = 1'b1;  // IF during IDLE
    tick();  // START, IF still high
    total++;
    if ({ALUstr, gnt0, opCode} !== 6'b11_0110) $display("FAIL spur_start got=%b exp=110110", {ALUstr, gnt0, opCode}); else passed++;
    tick();  // WAIT1
    total++;
    if ({busy, ack0} !== 2'b10) $display("FAIL spur_no_early got=%b exp=10", {busy, ack0}); else passed++;
    IF = 1'b0; req0 = 1'b0;
    tick();  // WAIT2
    total++;
    if ({gnt0, ack0} !== 2'b10) $display("FAIL spur_drop got=%b exp=10", {gnt0, ack0}); else passed++;
    IF = 1'b1;
    tick();  // DONE
    total++;
    if ({ack0, ack1, err} !== 3'b100) $display("FAIL spur_ack got=%b exp=100", {ack0, ack1, err}); else passed++;
    IF = 1'b0;
    tick();
    total++;
    if ({busy, ack0} !== 2'b00) $display("FAIL spur_idle got=%b exp=00", {busy, ack0}); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_if_at_limit();
    test_reset_mid();
    test_spurious();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
